// File: rtl/lpdi_wta_lrcheck.sv
// lpdi_wta_lrcheck: pipelined winner-takes-all over the left and right
// aggregated cost volumes followed by a left-right consistency check.
// One disparity per advance (en && pixelEN), latency DISP_W+1 advances.
// Optional: define LPDI_WTA_COST_OUT_EN to add min_cost_out (winning left cost).
module lpdi_wta_lrcheck #(
  parameter int MAXDISPARITY = 64,
  parameter int LPDI_WIDTH   = 8,
  parameter int INPUTDATAWID = 513,
  parameter int DISP_W       = 6,
  parameter int COL_W        = 11,
  parameter int LR_THRESH    = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    pixelEN,
  input  logic                    sof_in,
  input  logic                    eol_in,
  input  logic [INPUTDATAWID-1:0] LPDiLeft_in,
  input  logic [INPUTDATAWID-1:0] LPDiRight_in,
  output logic [DISP_W-1:0]       disp_out,
  output logic                    disp_valid,
  output logic                    pix_valid,
  output logic                    sof_out,
  output logic                    eol_out
`ifdef LPDI_WTA_COST_OUT_EN
  ,
  output logic [LPDI_WIDTH-1:0]   min_cost_out
`endif
);

  localparam int LAT   = DISP_W + 1;
  localparam int NNODE = MAXDISPARITY - 1;

  typedef struct packed {
    logic [LPDI_WIDTH-1:0] cost;
    logic [DISP_W-1:0]     idx;
  } node_t;

  logic adv;
  assign adv = en && pixelEN;

  // Tree nodes in heap order: level l occupies [lvl_off(l) +: MAXDISPARITY>>(l+1)].
  node_t l_q [NNODE];
  node_t r_q [NNODE];

  function automatic int unsigned lvl_off(input int unsigned l);
    return int'(MAXDISPARITY) - (int'(MAXDISPARITY) >> l);
  endfunction

  // Left operand always carries the smaller index, so ties keep it.
  function automatic node_t pick(input node_t a, input node_t b);
    return (b.cost < a.cost) ? b : a;
  endfunction

  function automatic node_t leaf(input logic [INPUTDATAWID-1:0] v, input int unsigned k);
    node_t r;
    r.cost = v[k*LPDI_WIDTH +: LPDI_WIDTH];
    r.idx  = DISP_W'(k);
    return r;
  endfunction

  // WTA reduction trees, one registered level per compare stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NNODE; i++) begin
        l_q[i] <= '0;
        r_q[i] <= '0;
      end
    end else if (adv) begin
      for (int unsigned n = 0; n < MAXDISPARITY/2; n++) begin
        l_q[n] <= pick(leaf(LPDiLeft_in, 2*n),  leaf(LPDiLeft_in, 2*n+1));
        r_q[n] <= pick(leaf(LPDiRight_in, 2*n), leaf(LPDiRight_in, 2*n+1));
      end
      for (int unsigned l = 1; l < DISP_W; l++) begin
        for (int unsigned n = 0; n < (MAXDISPARITY >> (l+1)); n++) begin
          l_q[lvl_off(l)+n] <= pick(l_q[lvl_off(l-1)+2*n], l_q[lvl_off(l-1)+2*n+1]);
          r_q[lvl_off(l)+n] <= pick(r_q[lvl_off(l-1)+2*n], r_q[lvl_off(l-1)+2*n+1]);
        end
      end
    end
  end

  // cnt_q holds the column of the next pixel; eol forces it back to 0.
  logic [COL_W-1:0] cnt_q;
  logic [COL_W-1:0] col_cur;
  logic [COL_W-1:0] col_inc;
  logic [COL_W-1:0] col_q [DISP_W];

  assign col_cur = sof_in ? '0 : cnt_q;
  assign col_inc = (&col_cur) ? col_cur : col_cur + 1'b1;

  // Column counter and its delay line aligned with the tree levels.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      for (int unsigned i = 0; i < DISP_W; i++) col_q[i] <= '0;
    end else if (adv) begin
      cnt_q    <= eol_in ? '0 : col_inc;
      col_q[0] <= col_cur;
      for (int unsigned i = 1; i < DISP_W; i++) col_q[i] <= col_q[i-1];
    end
  end

  // Fill marker plus sof/eol delay lines, LAT stages each.
  logic [LAT-1:0] fill_q;
  logic [LAT-1:0] sof_q;
  logic [LAT-1:0] eol_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fill_q <= '0;
      sof_q  <= '0;
      eol_q  <= '0;
    end else if (adv) begin
      fill_q <= {fill_q[LAT-2:0], 1'b1};
      sof_q  <= {sof_q[LAT-2:0], sof_in};
      eol_q  <= {eol_q[LAT-2:0], eol_in};
    end
  end

  assign pix_valid = fill_q[LAT-1];
  assign sof_out   = sof_q[LAT-1];
  assign eol_out   = eol_q[LAT-1];

  // Check stage inputs: tree winners and the right-disparity history.
  node_t lw;
  node_t rw;
  logic [DISP_W-1:0] hist_q [MAXDISPARITY-1];
  logic [DISP_W-1:0] dr_sel;
  logic [DISP_W-1:0] diff;
  logic              range_ok;
  logic              lr_ok;
  logic              valid;

  assign lw = l_q[NNODE-1];
  assign rw = r_q[NNODE-1];

  // LR consistency: compare dL against the right winner dL pixels back.
  always_comb begin
    dr_sel   = (lw.idx == '0) ? rw.idx : hist_q[lw.idx - 1'b1];
    diff     = (lw.idx >= dr_sel) ? (lw.idx - dr_sel) : (dr_sel - lw.idx);
    lr_ok    = int'(diff) <= LR_THRESH;
    range_ok = col_q[DISP_W-1] >= COL_W'(lw.idx);
    // Fill bubbles after reset never report a valid disparity.
    valid    = fill_q[DISP_W-1] && range_ok && lr_ok;
  end

  // Past right winners; hist_q[0] is the previous pixel's dR.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < MAXDISPARITY-1; i++) hist_q[i] <= '0;
    end else if (adv) begin
      hist_q[0] <= rw.idx;
      for (int unsigned i = 1; i < MAXDISPARITY-1; i++) hist_q[i] <= hist_q[i-1];
    end
  end

  logic [DISP_W-1:0] disp_q;
  logic              dv_q;

  // Registered check-stage outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      disp_q <= '0;
      dv_q   <= 1'b0;
    end else if (adv) begin
      disp_q <= valid ? lw.idx : '0;
      dv_q   <= valid;
    end
  end

  assign disp_out   = disp_q;
  assign disp_valid = dv_q;

`ifdef LPDI_WTA_COST_OUT_EN
  logic [LPDI_WIDTH-1:0] cost_q;

  // Winning left cost, saturated to all-ones for rejected pixels.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cost_q <= '0;
    end else if (adv) begin
      cost_q <= valid ? lw.cost : '1;
    end
  end

  assign min_cost_out = cost_q;
`endif

  logic unused_bits;
  assign unused_bits = ^{LPDiLeft_in[INPUTDATAWID-1], LPDiRight_in[INPUTDATAWID-1],
                         rw.cost, lw.cost};

endmodule

// File: tb/tb_lpdi_wta_lrcheck.sv
// Randomized self-checking bench for lpdi_wta_lrcheck against a pixel-list model.
module tb_lpdi_wta_lrcheck;

  localparam int MAXD   = 64;
  localparam int LW     = 8;
  localparam int INW    = LW*MAXD + 1;
  localparam int DW     = 6;
  localparam int CW     = 11;
  localparam int THR    = 1;
  localparam int LAT    = DW + 1;
  localparam int COLMAX = (1 << CW) - 1;

  logic           clk = 1'b0;
  logic           rst_n, en, pixelEN, sof_in, eol_in;
  logic [INW-1:0] lv, rv;
  logic [DW-1:0]  disp_out;
  logic           disp_valid, pix_valid, sof_out, eol_out;
`ifdef LPDI_WTA_COST_OUT_EN
  logic [LW-1:0]  min_cost_out;
`endif

  lpdi_wta_lrcheck #(
    .MAXDISPARITY(MAXD), .LPDI_WIDTH(LW), .INPUTDATAWID(INW),
    .DISP_W(DW), .COL_W(CW), .LR_THRESH(THR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pixelEN(pixelEN),
    .sof_in(sof_in), .eol_in(eol_in),
    .LPDiLeft_in(lv), .LPDiRight_in(rv),
    .disp_out(disp_out), .disp_valid(disp_valid), .pix_valid(pix_valid),
    .sof_out(sof_out), .eol_out(eol_out)
`ifdef LPDI_WTA_COST_OUT_EN
    , .min_cost_out(min_cost_out)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Current input volumes as plain integers.
  int lc [MAXD];
  int rc [MAXD];
  int stall_on;

  // Model: every pixel since reset, plus the expected output state.
  int q_dl[$], q_dr[$], q_col[$], q_cost[$], q_sof[$], q_eol[$];
  int nadv, prev_col, prev_eol;
  int e_disp, e_dv, e_pv, e_sof, e_eol, e_cost;

  function automatic int argmin(input int a [MAXD]);
    int b = 0;
    for (int k = 1; k < MAXD; k++) if (a[k] < a[b]) b = k;
    return b;
  endfunction

  task automatic model_step();
    int col, q, dl, sel, dif;
    bit ok;
    if (!rst_n) begin
      q_dl.delete(); q_dr.delete(); q_col.delete();
      q_cost.delete(); q_sof.delete(); q_eol.delete();
      nadv = 0; prev_col = 0; prev_eol = 0;
      e_disp = 0; e_dv = 0; e_pv = 0; e_sof = 0; e_eol = 0; e_cost = 0;
    end else if (en && pixelEN) begin
      if (nadv == 0 || sof_in || prev_eol != 0) col = 0;
      else col = (prev_col < COLMAX) ? prev_col + 1 : COLMAX;
      prev_col = col;
      prev_eol = int'(eol_in);
      q_dl.push_back(argmin(lc));
      q_dr.push_back(argmin(rc));
      q_cost.push_back(lc[argmin(lc)]);
      q_col.push_back(col);
      q_sof.push_back(int'(sof_in));
      q_eol.push_back(int'(eol_in));
      nadv++;
      e_pv = (nadv >= LAT) ? 1 : 0;
      q = nadv - LAT;
      if (q < 0) begin
        e_disp = 0; e_dv = 0; e_sof = 0; e_eol = 0; e_cost = 255;
      end else begin
        dl = q_dl[q];
        ok = 1'b0;
        if (q_col[q] >= dl) begin
          sel = q_dr[q - dl];
          dif = (dl > sel) ? dl - sel : sel - dl;
          ok  = (dif <= THR);
        end
        e_disp = ok ? dl : 0;
        e_dv   = ok ? 1 : 0;
        e_cost = ok ? q_cost[q] : 255;
        e_sof  = q_sof[q];
        e_eol  = q_eol[q];
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("disp_out",   int'(disp_out),   e_disp);
    chk("disp_valid", int'(disp_valid), e_dv);
    chk("pix_valid",  int'(pix_valid),  e_pv);
    chk("sof_out",    int'(sof_out),    e_sof);
    chk("eol_out",    int'(eol_out),    e_eol);
`ifdef LPDI_WTA_COST_OUT_EN
    chk("min_cost",   int'(min_cost_out), e_cost);
`endif
  endtask

  // mode 0: clear minima at dl/dr; 1: fixed tie 10@3,10@40,50 elsewhere;
  // 2: fully random costs; 3: like 0 with an equal left minimum at a higher index.
  task automatic set_vol(input int dl, input int dr, input int mode);
    for (int k = 0; k < MAXD; k++) begin
      lc[k] = int'($urandom_range(255, 30));
      rc[k] = int'($urandom_range(255, 30));
    end
    lc[dl] = int'($urandom_range(20, 0));
    rc[dr] = int'($urandom_range(20, 0));
    if (mode == 1) begin
      for (int k = 0; k < MAXD; k++) lc[k] = 50;
      lc[3] = 10; lc[40] = 10;
    end else if (mode == 2) begin
      for (int k = 0; k < MAXD; k++) begin
        lc[k] = int'($urandom_range(255, 0));
        rc[k] = int'($urandom_range(255, 0));
      end
    end else if (mode == 3 && dl < MAXD-1) begin
      lc[$urandom_range(MAXD-1, dl+1)] = lc[dl];
    end
    for (int k = 0; k < MAXD; k++) begin
      lv[k*LW +: LW] = LW'(lc[k]);
      rv[k*LW +: LW] = LW'(rc[k]);
    end
    lv[INW-1] = 1'($urandom);
    rv[INW-1] = 1'($urandom);
  endtask

  // Present one pixel and hold it until it is taken (bounded stalls).
  task automatic send(input int dl, input int dr, input int mode, input bit s, input bit e);
    bit took;
    set_vol(dl, dr, mode);
    sof_in = s;
    eol_in = e;
    for (int t = 0; t < 4; t++) begin
      if (stall_on == 0 || t == 3) begin
        en = 1'b1; pixelEN = 1'b1;
      end else begin
        en      = ($urandom % 8) != 0;
        pixelEN = ($urandom % 4) != 0;
      end
      took = en && pixelEN;
      tick();
      if (took) break;
    end
  endtask

  function automatic int jit(input int d);
    int r = int'($urandom % 6);
    if (r == 3) return (d < MAXD-1) ? d + 1 : d;
    if (r == 4) return (d > 0) ? d - 1 : d;
    if (r == 5) return int'($urandom_range(MAXD-1, 0));
    return d;
  endfunction

  task automatic line(input int len, input bit first_sof, input bit last_eol);
    int d = int'($urandom_range(20, 0));
    int m;
    for (int x = 0; x < len; x++) begin
      m = ($urandom % 10 == 0) ? 2 : (($urandom % 8 == 0) ? 3 : 0);
      send(jit(d), jit(d), m, first_sof && x == 0, last_eol && x == len-1);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; pixelEN = 1'b0; sof_in = 1'b0; eol_in = 1'b0;
    lv = '0; rv = '0; stall_on = 0;
    for (int k = 0; k < MAXD; k++) begin lc[k] = 0; rc[k] = 0; end
    repeat (3) tick();
    rst_n = 1'b1;

    // Directed line: dL=5 region, tie pixel, then dL=10 against dR 13 / 11.
    for (int i = 0; i < 30; i++) begin
      int dl, dr;
      dl = (i < 12) ? 5 : 10;
      dr = (i == 12) ? 13 : (i == 13) ? 11 : dl;
      send(dl, dr, (i == 3) ? 1 : 0, i == 0, i == 29);
      if (i == 6 || i == 20) begin
        pixelEN = 1'b0;
        tick();
        tick();
      end
    end

    // Random lines with stalls, including single-pixel sof+eol lines.
    stall_on = 1;
    for (int n = 0; n < 8; n++) begin
      if (n == 4) line(1, 1'b1, 1'b1);
      else line(int'($urandom_range(70, 20)), n == 0, 1'b1);
    end

    // Reset in the middle of a line, then restart on a new sof.
    line(15, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int n = 0; n < 4; n++) line(int'($urandom_range(60, 10)), n == 0, 1'b1);

    stall_on = 0;
    line(LAT + 3, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
